// File: rtl/not_response_checker.sv
// not_response_checker
//   Drives one stimulus bit at a time into an inverter under test and checks
//   that dut_y == ~stim_a once the DUT has had SETTLE_CYCLES cycles to settle.
//   A run checks NUM_VEC vectors and then holds its verdict in DONE.
//
//   Optional feature: define NOT_CHECKER_FIRST_FAIL_EN to capture the index of
//   the first mismatching vector on first_fail_idx. If it is undefined, that
//   port is tied to 0.
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   start                : begins a run (honoured in IDLE/DONE only)
//   stim_valid, stim_a   : stimulus handshake and stimulus bit
//   dut_y                : DUT output under check (sampled in CHECK only)
//   stim_ready           : checker accepts a vector (WAIT_STIM)
//   busy, done, pass     : run status
//   vec_count, err_count : vectors checked and mismatches (saturating)
//   first_fail_idx       : index of the first mismatching vector
module not_response_checker #(
  parameter int NUM_VEC       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stim_valid,
  input  logic             stim_a,
  input  logic             dut_y,
  output logic             stim_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail_idx
);

  typedef enum logic [2:0] {IDLE, WAIT_STIM, SETTLE, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);
  localparam logic [7:0]       SETTLE_C  = 8'(SETTLE_CYCLES);

  state_t           state_q, state_d;
  logic [7:0]       settle_q, settle_d;
  logic             a_q, a_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             run_start;
  logic             mismatch;

  assign run_start = ((state_q == IDLE) || (state_q == DONE)) && start;
  // dut_y is only ever looked at in CHECK; everywhere else it is ignored.
  assign mismatch  = (state_q == CHECK) && (dut_y != ~a_q);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    a_d      = a_q;
    vec_d    = vec_q;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WAIT_STIM;
          vec_d   = '0;
          err_d   = '0;
        end
      end
      WAIT_STIM: begin
        if (stim_valid) begin
          a_d      = stim_a;
          settle_d = 8'd1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        // Counter starts at 1 on transfer, so SETTLE spans SETTLE_CYCLES cycles.
        if (settle_q == SETTLE_C) state_d  = CHECK;
        else                      settle_d = settle_q + 8'd1;
      end
      CHECK: begin
        vec_d = vec_q + 1'b1;
        if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
        state_d = (vec_d == NUM_VEC_C) ? DONE : WAIT_STIM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
      a_q      <= 1'b0;
      vec_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
    end
  end

`ifdef NOT_CHECKER_FIRST_FAIL_EN
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;

  // err_q saturates and never wraps, so err_q == 0 marks the first mismatch.
  always_comb begin
    ff_idx_d = ff_idx_q;
    if (run_start)                    ff_idx_d = '0;
    else if (mismatch && err_q == '0) ff_idx_d = vec_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff_idx_q <= '0;
    else       ff_idx_q <= ff_idx_d;
  end

  assign first_fail_idx = ff_idx_q;
`else
  assign first_fail_idx = '0;
`endif

  assign stim_ready = (state_q == WAIT_STIM);
  assign busy       = (state_q == WAIT_STIM) || (state_q == SETTLE) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == '0);
  assign vec_count  = vec_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_not_response_checker.sv
module tb_not_response_checker;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, stim_valid, stim_a;
  logic [1:0] y_mode;  // 0: good inverter, 1: stuck at 0, 2: stuck at 1
  logic       dut_y;
  logic       stim_ready, busy, done, pass;
  logic [7:0] vec_count, err_count, ff_idx;

  assign dut_y = (y_mode == 2'd0) ? ~stim_a : (y_mode == 2'd1) ? 1'b0 : 1'b1;

  not_response_checker #(.NUM_VEC(4), .SETTLE_CYCLES(S), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stim_valid(stim_valid),
    .stim_a(stim_a), .dut_y(dut_y), .stim_ready(stim_ready), .busy(busy),
    .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
    .first_fail_idx(ff_idx));

  // Small instance: every vector fails (dut_y2 follows the stimulus, not its inverse).
  logic       start2, valid2, a2, dut_y2;
  logic       ready2, busy2, done2, pass2;
  logic [1:0] vc2, ec2, ff2;
  assign dut_y2 = a2;

  not_response_checker #(.NUM_VEC(3), .SETTLE_CYCLES(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start2), .stim_valid(valid2),
    .stim_a(a2), .dut_y(dut_y2), .stim_ready(ready2), .busy(busy2),
    .done(done2), .pass(pass2), .vec_count(vc2), .err_count(ec2),
    .first_fail_idx(ff2));

  int n_chk = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!stim_ready && k < 50) begin tick(); k++; end
    n_chk++;
    if (stim_ready !== 1'b1) begin n_fail++; $display("FAIL wait_ready: stim_ready=%b required 1", stim_ready); end
  endtask

  task automatic send(input logic a);
    wait_ready();
    stim_a = a; stim_valid = 1'b1;
    tick();
    stim_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 100) begin tick(); k++; end
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL wait_done: done=%b required 1", done); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; stim_valid = 0; stim_a = 0; y_mode = 0;
    start2 = 0; valid2 = 0; a2 = 0;
    #12;
    n_chk++;
    if ({stim_ready, busy, done, pass, vec_count, err_count, ff_idx} !== 28'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required all 0",
                         {stim_ready, busy, done, pass, vec_count, err_count, ff_idx});
    end
    n_chk++;
    if ({ready2, busy2, done2, pass2, vc2, ec2, ff2} !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs_sat: got %b required all 0", {ready2, busy2, done2, pass2, vc2, ec2, ff2});
    end
    tick(); reset = 1'b0;
  endtask

  task automatic test_good_inverter();
    pulse_start();  // first edge after reset release
    n_chk++;
    if ({stim_ready, busy, done, pass} !== 4'b1100) begin
      n_fail++; $display("FAIL start_after_reset: rdy/busy/done/pass=%b required 1100", {stim_ready, busy, done, pass});
    end
    send(0); send(1); send(0); send(1);
    wait_done();
    n_chk++;
    if ({busy, stim_ready, pass, vec_count, err_count, ff_idx} !== {3'b001, 8'd4, 8'd0, 8'd0}) begin
      n_fail++; $display("FAIL good_inverter: busy=%b rdy=%b pass=%b vec=%0d err=%0d ff=%0d required 0 0 1 4 0 0",
                         busy, stim_ready, pass, vec_count, err_count, ff_idx);
    end
  endtask

  task automatic test_stuck();
    logic [7:0] exp_ff;
    // Stuck at 0: expected ~a = 1,0,1,0 -> mismatches at vectors 0 and 2.
    y_mode = 2'd1;
    pulse_start();
    send(0); send(1); send(0); send(1);
    wait_done();
    n_chk++;
    if ({pass, err_count, ff_idx} !== {1'b0, 8'd2, 8'd0}) begin
      n_fail++; $display("FAIL stuck0: pass=%b err=%0d ff=%0d required 0 2 0", pass, err_count, ff_idx);
    end
    // Stuck at 1: mismatches at vectors 1 and 3. Restart from DONE clears counters.
    y_mode = 2'd2;
    pulse_start();
    n_chk++;
    if ({done, busy, vec_count, err_count} !== {2'b01, 8'd0, 8'd0}) begin
      n_fail++; $display("FAIL restart_clear: done=%b busy=%b vec=%0d err=%0d required 0 1 0 0",
                         done, busy, vec_count, err_count);
    end
    send(0); send(1); send(0); send(1);
    wait_done();
`ifdef NOT_CHECKER_FIRST_FAIL_EN
    exp_ff = 8'd1;
`else
    exp_ff = 8'd0;
`endif
    n_chk++;
    if ({pass, vec_count, err_count, ff_idx} !== {1'b0, 8'd4, 8'd2, exp_ff}) begin
      n_fail++; $display("FAIL stuck1: pass=%b vec=%0d err=%0d ff=%0d required 0 4 2 %0d",
                         pass, vec_count, err_count, ff_idx, exp_ff);
    end
  endtask

  task automatic test_start_ignored();
    y_mode = 2'd0;
    pulse_start();
    send(0); send(1);
    wait_ready();
    pulse_start();  // in WAIT_STIM: must be ignored
    n_chk++;
    if ({vec_count, busy, done} !== {8'd2, 2'b10}) begin
      n_fail++; $display("FAIL start_ignored_wait: vec=%0d busy=%b done=%b required 2 1 0", vec_count, busy, done);
    end
    send(0);
    pulse_start();  // in SETTLE: must be ignored
    send(1);
    wait_done();
    n_chk++;
    if ({vec_count, err_count, pass} !== {8'd4, 8'd0, 1'b1}) begin
      n_fail++; $display("FAIL start_ignored_end: vec=%0d err=%0d pass=%b required 4 0 1", vec_count, err_count, pass);
    end
  endtask

  task automatic test_no_timeout();
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      y_mode = (i % 2 == 0) ? 2'd1 : 2'd2;  // dut_y wiggles with no vector in flight
      tick();
    end
    n_chk++;
    if ({stim_ready, busy, vec_count, err_count} !== {2'b11, 8'd0, 8'd0}) begin
      n_fail++; $display("FAIL no_timeout: rdy=%b busy=%b vec=%0d err=%0d required 1 1 0 0",
                         stim_ready, busy, vec_count, err_count);
    end
    y_mode = 2'd0;
    send(1); send(1); send(0); send(0);
    wait_done();
    n_chk++;
    if ({pass, err_count} !== {1'b1, 8'd0}) begin
      n_fail++; $display("FAIL dut_y_outside_check: pass=%b err=%0d required 1 0", pass, err_count);
    end
  endtask

  task automatic test_back_to_back();
    int nx = 0;
    int last = 0;
    int cyc = 0;
    y_mode = 2'd0;
    pulse_start();
    stim_valid = 1'b1;
    while (!done && cyc < 60) begin
      if (stim_ready) begin
        if (nx > 0) begin
          n_chk++;
          if (cyc - last != S + 2) begin
            n_fail++; $display("FAIL b2b_period: ready gap=%0d required %0d", cyc - last, S + 2);
          end
        end
        stim_a = nx[0];
        last = cyc;
        nx++;
      end
      tick(); cyc++;
    end
    stim_valid = 1'b0;
    n_chk++;
    if (nx != 4 || done !== 1'b1 || pass !== 1'b1) begin
      n_fail++; $display("FAIL b2b_transfers: transfers=%0d done=%b pass=%b required 4 1 1", nx, done, pass);
    end
  endtask

  task automatic test_reset_mid_settle();
    pulse_start();
    send(1);
    send(0);  // returns one cycle into SETTLE of vector 1
    n_chk++;
    if ({vec_count, busy, stim_ready} !== {8'd1, 2'b10}) begin
      n_fail++; $display("FAIL pre_reset: vec=%0d busy=%b rdy=%b required 1 1 0", vec_count, busy, stim_ready);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({stim_ready, busy, done, pass, vec_count, err_count, ff_idx} !== 28'd0) begin
      n_fail++; $display("FAIL reset_mid_settle: got %b required all 0",
                         {stim_ready, busy, done, pass, vec_count, err_count, ff_idx});
    end
    @(posedge clk); #1 reset = 1'b0;
    tick();
    n_chk++;
    if ({stim_ready, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: rdy/busy/done=%b required 000", {stim_ready, busy, done});
    end
    pulse_start();
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_after_reset: busy=%b required 1", busy); end
  endtask

  task automatic test_saturation();
    for (int run = 0; run < 2; run++) begin
      start2 = 1'b1; tick(); start2 = 1'b0;
      n_chk++;
      if ({ec2, vc2, busy2} !== 5'b00001) begin
        n_fail++; $display("FAIL sat_start_run%0d: err=%0d vec=%0d busy=%b required 0 0 1", run, ec2, vc2, busy2);
      end
      for (int v = 0; v < 3; v++) begin
        int k = 0;
        while (!ready2 && k < 50) begin tick(); k++; end
        a2 = v[0]; valid2 = 1'b1; tick(); valid2 = 1'b0;
      end
      begin
        int k = 0;
        while (!done2 && k < 50) begin tick(); k++; end
      end
      n_chk++;
      if ({done2, pass2, vc2, ec2} !== {2'b10, 2'd3, 2'd3}) begin
        n_fail++; $display("FAIL sat_run%0d: done=%b pass=%b vec=%0d err=%0d required 1 0 3 3", run, done2, pass2, vc2, ec2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_inverter();
    test_stuck();
    test_start_ignored();
    test_no_timeout();
    test_back_to_back();
    test_reset_mid_settle();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
